equation_scheduler: RTL and testbench

//  Session controller for the alarm puzzle. On an alarm trigger it starts the equation units one at a

---
 rtl/equation_scheduler.sv | 124 ++++++++++++
 tb/tb_equation_scheduler.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/equation_scheduler.sv
// Alarm-puzzle session controller: launches equation units round-robin, times each attempt,
// and ends the session after REQUIRED_CORRECT consecutive correct answers.
module equation_scheduler #(
   parameter int unsigned NUM_EQ           = 3,
   parameter int unsigned TIME_LIMIT       = 30,
   parameter int unsigned REQUIRED_CORRECT = 3
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              alarm_trigger,
   input  logic              tick,
   input  logic [NUM_EQ-1:0] eq_done,
   input  logic [NUM_EQ-1:0] eq_correct,
   output logic [NUM_EQ-1:0] eq_start,
   output logic [NUM_EQ-1:0] eq_reset,
   output logic [6:0]        ongoing_timer,
   output logic [1:0]        active_eq,
   output logic [2:0]        streak,
   output logic              alarm_on,
   output logic              session_done
);

   typedef enum logic [2:0] {
      StIdle, StLaunch, StWait, StEvalOk, StEvalFail, StClear, StDone
   } state_e;

   localparam logic [6:0] TimerInit  = 7'(TIME_LIMIT);
   localparam logic [2:0] StreakGoal = 3'(REQUIRED_CORRECT);
   localparam logic [1:0] LastIdx    = 2'(NUM_EQ - 1);

   state_e     state_q, state_d;
   logic [1:0] idx_q, idx_d;
   logic [6:0] timer_q, timer_d;
   logic [2:0] streak_q, streak_d;
   logic       done_sel, correct_sel;

   // Only the active unit's handshake is observed.
   always_comb begin
      done_sel    = 1'b0;
      correct_sel = 1'b0;
      for (int i = 0; i < NUM_EQ; i++) begin
         if (idx_q == 2'(i)) begin
            done_sel    = eq_done[i];
            correct_sel = eq_correct[i];
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      timer_d  = timer_q;
      streak_d = streak_q;
      unique case (state_q)
         StIdle: begin
            if (alarm_trigger) begin
               state_d  = StLaunch;
               streak_d = '0;
               idx_d    = '0;
            end
         end
         StLaunch: begin
            timer_d = TimerInit;
            state_d = StWait;
         end
         StWait: begin
            if (tick && (timer_q != 7'd0)) timer_d = timer_q - 7'd1;
            // Current timer value is used, so a correct answer on the final tick still wins.
            if (done_sel && correct_sel)  state_d = StEvalOk;
            else if (done_sel)            state_d = StEvalFail;
            else if (timer_q == 7'd0)     state_d = StEvalFail;
         end
         StEvalOk: begin
            streak_d = streak_q + 3'd1;
            state_d  = ((streak_q + 3'd1) == StreakGoal) ? StDone : StClear;
         end
         StEvalFail: begin
            streak_d = '0;
            state_d  = StClear;
         end
         StClear: begin
            idx_d   = (idx_q == LastIdx) ? 2'd0 : idx_q + 2'd1;
            state_d = StLaunch;
         end
         StDone: begin
            idx_d   = '0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q  <= StIdle;
         idx_q    <= '0;
         timer_q  <= '0;
         streak_q <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         timer_q  <= timer_d;
         streak_q <= streak_d;
      end
   end

   always_comb begin
      eq_start = '0;
      eq_reset = '0;
      for (int i = 0; i < NUM_EQ; i++) begin
         if (idx_q == 2'(i)) begin
            eq_start[i] = (state_q == StLaunch) || (state_q == StWait);
            eq_reset[i] = (state_q == StClear) || (state_q == StDone);
         end
      end
      alarm_on      = (state_q == StLaunch) || (state_q == StWait) || (state_q == StEvalOk) ||
                      (state_q == StEvalFail) || (state_q == StClear);
      session_done  = (state_q == StDone);
      ongoing_timer = timer_q;
      active_eq     = idx_q;
      streak        = streak_q;
   end

endmodule

// File: tb/tb_equation_scheduler.sv
// Directed bench for equation_scheduler with default parameters (3 units, 30 s, 3 in a row).
module tb_equation_scheduler;

   logic       Clock = 1'b0;
   logic       Reset = 1'b1;
   logic       alarm_trigger = 1'b0;
   logic       tick = 1'b0;
   logic [2:0] eq_done = '0;
   logic [2:0] eq_correct = '0;
   logic [2:0] eq_start, eq_reset;
   logic [6:0] ongoing_timer;
   logic [1:0] active_eq;
   logic [2:0] streak;
   logic       alarm_on, session_done;

   int checks = 0;
   int fails  = 0;

   equation_scheduler #(
      .NUM_EQ(3), .TIME_LIMIT(30), .REQUIRED_CORRECT(3)
   ) dut (
      .Clock(Clock), .Reset(Reset), .alarm_trigger(alarm_trigger), .tick(tick),
      .eq_done(eq_done), .eq_correct(eq_correct), .eq_start(eq_start), .eq_reset(eq_reset),
      .ongoing_timer(ongoing_timer), .active_eq(active_eq), .streak(streak),
      .alarm_on(alarm_on), .session_done(session_done)
   );

   always #5 Clock = ~Clock;

   // Advance to just after the next rising edge; inputs set here are seen at the following edge.
   task automatic cyc();
      @(posedge Clock);
      #1;
   endtask

   task automatic apply_reset();
      Reset = 1'b1;
      alarm_trigger = 1'b0; tick = 1'b0; eq_done = '0; eq_correct = '0;
      cyc(); cyc();
      Reset = 1'b0;
      cyc();
   endtask

   // IDLE -> LAUNCH -> WAIT, ends in WAIT
   task automatic start_session();
      alarm_trigger = 1'b1;
      cyc();
      alarm_trigger = 1'b0;
      cyc();
   endtask

   // From WAIT: answer, then EVAL, ends in CLEAR (or DONE)
   task automatic answer(input int unit, input logic ok);
      eq_done = '0; eq_correct = '0;
      eq_done[unit] = 1'b1;
      eq_correct[unit] = ok;
      cyc();
      eq_done = '0; eq_correct = '0;
      cyc();
   endtask

   task automatic test_reset();
      apply_reset();
      checks++; if (eq_start !== 3'b000) begin fails++; $display("FAIL reset_start got %b want 000", eq_start); end
      checks++; if (eq_reset !== 3'b000) begin fails++; $display("FAIL reset_ereset got %b want 000", eq_reset); end
      checks++; if (ongoing_timer !== 7'd0) begin fails++; $display("FAIL reset_timer got %0d want 0", ongoing_timer); end
      checks++; if ({alarm_on, session_done, streak, active_eq} !== 7'd0) begin fails++; $display("FAIL reset_misc got %b want 0", {alarm_on, session_done, streak, active_eq}); end
   endtask

   task automatic test_three_correct();
      apply_reset();
      alarm_trigger = 1'b1; cyc(); alarm_trigger = 1'b0;
      checks++; if (eq_start !== 3'b001) begin fails++; $display("FAIL launch_start got %b want 001", eq_start); end
      checks++; if (alarm_on !== 1'b1) begin fails++; $display("FAIL launch_alarm got %b want 1", alarm_on); end
      cyc();
      checks++; if (ongoing_timer !== 7'd30) begin fails++; $display("FAIL wait_timer got %0d want 30", ongoing_timer); end
      answer(0, 1'b1);
      checks++; if (streak !== 3'd1) begin fails++; $display("FAIL ok_streak1 got %0d want 1", streak); end
      checks++; if (eq_reset !== 3'b001) begin fails++; $display("FAIL ok_reset0 got %b want 001", eq_reset); end
      checks++; if (eq_start !== 3'b000) begin fails++; $display("FAIL clear_start got %b want 000", eq_start); end
      cyc();
      checks++; if (eq_start !== 3'b010) begin fails++; $display("FAIL launch1_start got %b want 010", eq_start); end
      cyc();
      answer(1, 1'b1);
      checks++; if (streak !== 3'd2) begin fails++; $display("FAIL ok_streak2 got %0d want 2", streak); end
      cyc(); cyc();
      checks++; if (active_eq !== 2'd2) begin fails++; $display("FAIL active2 got %0d want 2", active_eq); end
      answer(2, 1'b1);
      checks++; if (streak !== 3'd3) begin fails++; $display("FAIL ok_streak3 got %0d want 3", streak); end
      checks++; if (session_done !== 1'b1) begin fails++; $display("FAIL done_pulse got %b want 1", session_done); end
      checks++; if (eq_reset !== 3'b100) begin fails++; $display("FAIL done_reset got %b want 100", eq_reset); end
      checks++; if (alarm_on !== 1'b0) begin fails++; $display("FAIL done_alarm got %b want 0", alarm_on); end
      cyc();
      checks++; if ({session_done, alarm_on, eq_start} !== 5'd0) begin fails++; $display("FAIL idle_after got %b want 0", {session_done, alarm_on, eq_start}); end
      checks++; if (active_eq !== 2'd0) begin fails++; $display("FAIL idle_idx got %0d want 0", active_eq); end
   endtask

   task automatic test_correct_then_wrong();
      apply_reset();
      start_session();
      tick = 1'b1; repeat (5) cyc(); tick = 1'b0;
      checks++; if (ongoing_timer !== 7'd25) begin fails++; $display("FAIL tick5_timer got %0d want 25", ongoing_timer); end
      answer(0, 1'b1);
      checks++; if (streak !== 3'd1) begin fails++; $display("FAIL cw_streak1 got %0d want 1", streak); end
      cyc(); cyc();
      tick = 1'b1; repeat (4) cyc(); tick = 1'b0;
      answer(1, 1'b0);
      checks++; if (streak !== 3'd0) begin fails++; $display("FAIL cw_streak0 got %0d want 0", streak); end
      checks++; if (ongoing_timer !== 7'd26) begin fails++; $display("FAIL cw_hold got %0d want 26", ongoing_timer); end
      checks++; if (eq_reset !== 3'b010) begin fails++; $display("FAIL cw_reset1 got %b want 010", eq_reset); end
      cyc();
      checks++; if (eq_start !== 3'b100) begin fails++; $display("FAIL cw_start2 got %b want 100", eq_start); end
      cyc();
      checks++; if (ongoing_timer !== 7'd30) begin fails++; $display("FAIL cw_reload got %0d want 30", ongoing_timer); end
   endtask

   task automatic test_timeout();
      apply_reset();
      start_session();
      for (int n = 1; n <= 30; n++) begin
         tick = 1'b1; cyc();
         checks++; if (ongoing_timer !== 7'(30 - n)) begin fails++; $display("FAIL to_timer got %0d want %0d", ongoing_timer, 30 - n); end
      end
      tick = 1'b0;
      checks++; if (eq_start !== 3'b001) begin fails++; $display("FAIL to_still_wait got %b want 001", eq_start); end
      cyc();
      checks++; if ({eq_start, alarm_on} !== 4'b0001) begin fails++; $display("FAIL to_eval got %b want 0001", {eq_start, alarm_on}); end
      cyc();
      checks++; if (eq_reset !== 3'b001) begin fails++; $display("FAIL to_reset0 got %b want 001", eq_reset); end
      cyc();
      checks++; if (eq_start !== 3'b010) begin fails++; $display("FAIL to_start1 got %b want 010", eq_start); end
      cyc();
      checks++; if (ongoing_timer !== 7'd30) begin fails++; $display("FAIL to_reload got %0d want 30", ongoing_timer); end
   endtask

   task automatic test_last_tick_correct();
      apply_reset();
      start_session();
      tick = 1'b1; repeat (29) cyc();
      eq_done = 3'b001; eq_correct = 3'b001;
      cyc();
      tick = 1'b0; eq_done = '0; eq_correct = '0;
      checks++; if (ongoing_timer !== 7'd0) begin fails++; $display("FAIL lt_timer got %0d want 0", ongoing_timer); end
      cyc();
      checks++; if (streak !== 3'd1) begin fails++; $display("FAIL lt_streak got %0d want 1", streak); end
   endtask

   task automatic test_spurious_and_wrap();
      apply_reset();
      start_session();
      eq_done = 3'b100; eq_correct = 3'b100; alarm_trigger = 1'b1;
      cyc();
      eq_done = '0; eq_correct = '0; alarm_trigger = 1'b0;
      checks++; if (eq_start !== 3'b001) begin fails++; $display("FAIL sp_start got %b want 001", eq_start); end
      checks++; if ({alarm_on, streak, ongoing_timer} !== {1'b1, 3'd0, 7'd30}) begin fails++; $display("FAIL sp_state got %b want 1_000_0011110", {alarm_on, streak, ongoing_timer}); end
      answer(0, 1'b0); cyc(); cyc();
      answer(1, 1'b0); cyc(); cyc();
      answer(2, 1'b0);
      checks++; if (eq_reset !== 3'b100) begin fails++; $display("FAIL wrap_reset got %b want 100", eq_reset); end
      cyc();
      checks++; if ({active_eq, eq_start} !== 5'b00_001) begin fails++; $display("FAIL wrap_start got %b want 00001", {active_eq, eq_start}); end
   endtask

   task automatic test_reset_mid_wait();
      apply_reset();
      start_session();
      answer(0, 1'b1); cyc(); cyc();
      tick = 1'b1; repeat (13) cyc(); tick = 1'b0;
      checks++; if ({eq_start, ongoing_timer} !== {3'b010, 7'd17}) begin fails++; $display("FAIL mid_pre got %b want 010_0010001", {eq_start, ongoing_timer}); end
      #3 Reset = 1'b1;
      #1;
      checks++; if ({eq_start, eq_reset, ongoing_timer, active_eq, streak, alarm_on, session_done} !== 20'd0) begin fails++; $display("FAIL mid_async got %b want 0", {eq_start, eq_reset, ongoing_timer, active_eq, streak, alarm_on, session_done}); end
      cyc(); cyc();
      Reset = 1'b0;
      cyc();
      checks++; if ({eq_start, alarm_on} !== 4'd0) begin fails++; $display("FAIL mid_idle got %b want 0", {eq_start, alarm_on}); end
      alarm_trigger = 1'b1; cyc(); alarm_trigger = 1'b0;
      checks++; if ({eq_start, active_eq} !== 5'b001_00) begin fails++; $display("FAIL mid_restart got %b want 00100", {eq_start, active_eq}); end
   endtask

   initial begin
      test_reset();
      test_three_correct();
      test_correct_then_wrong();
      test_timeout();
      test_last_tick_correct();
      test_spurious_and_wrap();
      test_reset_mid_wait();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
